// File: rtl/cmd_dispatcher.sv
// Command dispatcher: pulls fixed-length records from a FWFT FIFO, launches the compute
// engine once per record and counts completions, with NOP skip, illegal-op and watchdog errors.
module cmd_dispatcher #(
    parameter int unsigned       WORD_W     = 32,
    parameter int unsigned       CMD_WORDS  = 8,
    parameter int unsigned       CNT_W      = 7,
    parameter int unsigned       WDOG_W     = 16,
    parameter logic [WDOG_W-1:0] WDOG_LIMIT = 16'hFFFF
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        op_en,
    input  logic                        abort,
    input  logic                        irq_ack,
    input  logic                        valid,
    output logic                        rd_en,
    input  logic [WORD_W-1:0]           cmd,
    input  logic [CNT_W-1:0]            cmd_size,
    output logic [CMD_WORDS*WORD_W-1:0] cmd_rec,
    output logic [2:0]                  op_type,
    output logic                        engine_valid,
    input  logic                        engine_ready,
    output logic                        engine_reset,
    output logic [CNT_W-1:0]            done_cnt,
    output logic [2:0]                  curr_state,
    output logic                        irq,
    output logic                        err,
    output logic [1:0]                  err_code
);

    localparam int unsigned     REC_W    = CMD_WORDS * WORD_W;
    localparam int unsigned     IDX_W    = (CMD_WORDS > 1) ? $clog2(CMD_WORDS) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(CMD_WORDS - 1);

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_WDOG    = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'b000,
        ST_FETCH = 3'b001,
        ST_ISSUE = 3'b010,
        ST_RUN   = 3'b011,
        ST_DONE  = 3'b100,
        ST_ERROR = 3'b101
    } state_e;

    function automatic logic op_is_engine(input logic [2:0] op);
        case (op)
            3'b001, 3'b100, 3'b101: op_is_engine = 1'b1;
            default:                op_is_engine = 1'b0;
        endcase
    endfunction

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [REC_W-1:0]  rec_q, rec_d;
    logic [CNT_W-1:0]  done_q, done_d;
    logic [WDOG_W-1:0] wdog_q, wdog_d;
    logic              ev_q, ev_d;
    logic              er_q, er_d;
    logic              irq_q, irq_d;
    logic              err_q, err_d;
    logic [1:0]        code_q, code_d;

    logic [CNT_W-1:0]  done_inc_s;
    logic              last_rec_s;
    logic [WDOG_W-1:0] wdog_inc_s;
    logic              wdog_hit_s;
    logic [2:0]        op_s;

    assign done_inc_s = done_q + CNT_W'(1);
    assign last_rec_s = (done_inc_s == cmd_size);
    assign wdog_inc_s = wdog_q + WDOG_W'(1);
    // A zero limit disables the timeout entirely.
    assign wdog_hit_s = (WDOG_LIMIT != {WDOG_W{1'b0}}) && (wdog_inc_s == WDOG_LIMIT);
    assign op_s       = rec_q[2:0];

    // Next-state and register-update logic for the dispatcher FSM
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        rec_d   = rec_q;
        done_d  = done_q;
        wdog_d  = wdog_q;
        ev_d    = ev_q;
        er_d    = er_q;
        irq_d   = irq_q;
        err_d   = err_q;
        code_d  = code_q;

        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
            idx_d   = {IDX_W{1'b0}};
            wdog_d  = {WDOG_W{1'b0}};
            ev_d    = 1'b0;
            er_d    = 1'b1;
            irq_d   = 1'b0;
            err_d   = 1'b0;
            code_d  = ERR_NONE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    er_d = 1'b1;
                    if (op_en) begin
                        done_d = {CNT_W{1'b0}};
                        idx_d  = {IDX_W{1'b0}};
                        if (cmd_size != {CNT_W{1'b0}}) begin
                            state_d = ST_FETCH;
                        end else begin
                            state_d = ST_DONE;
                            irq_d   = 1'b1;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_FETCH: begin
                    if (valid) begin
                        rec_d[idx_q*WORD_W +: WORD_W] = cmd;
                        if (idx_q == IDX_LAST) begin
                            idx_d   = {IDX_W{1'b0}};
                            state_d = ST_ISSUE;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else begin
                        idx_d = idx_q;
                    end
                end
                ST_ISSUE: begin
                    if (op_is_engine(op_s)) begin
                        ev_d    = 1'b1;
                        er_d    = 1'b0;
                        wdog_d  = {WDOG_W{1'b0}};
                        state_d = ST_RUN;
                    end else if (op_s == 3'b000) begin
                        done_d = done_inc_s;
                        if (last_rec_s) begin
                            state_d = ST_DONE;
                            irq_d   = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else begin
                        err_d   = 1'b1;
                        code_d  = ERR_ILLEGAL;
                        irq_d   = 1'b1;
                        state_d = ST_ERROR;
                    end
                end
                ST_RUN: begin
                    // Completion takes precedence over a timeout in the same cycle.
                    if (engine_ready) begin
                        ev_d   = 1'b0;
                        er_d   = 1'b1;
                        wdog_d = {WDOG_W{1'b0}};
                        done_d = done_inc_s;
                        if (last_rec_s) begin
                            state_d = ST_DONE;
                            irq_d   = 1'b1;
                        end else begin
                            state_d = ST_FETCH;
                        end
                    end else if (wdog_hit_s) begin
                        ev_d    = 1'b0;
                        er_d    = 1'b1;
                        wdog_d  = {WDOG_W{1'b0}};
                        err_d   = 1'b1;
                        code_d  = ERR_WDOG;
                        irq_d   = 1'b1;
                        state_d = ST_ERROR;
                    end else begin
                        wdog_d = wdog_inc_s;
                    end
                end
                ST_DONE: begin
                    if (irq_ack) begin
                        irq_d   = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        irq_d = 1'b1;
                    end
                end
                ST_ERROR: begin
                    if (irq_ack) begin
                        irq_d   = 1'b0;
                        err_d   = 1'b0;
                        code_d  = ERR_NONE;
                        state_d = ST_IDLE;
                    end else begin
                        irq_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    idx_d   = {IDX_W{1'b0}};
                    ev_d    = 1'b0;
                    er_d    = 1'b1;
                    irq_d   = 1'b0;
                    err_d   = 1'b0;
                    code_d  = ERR_NONE;
                end
            endcase
        end
    end

    // State and datapath registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= {IDX_W{1'b0}};
            rec_q   <= {REC_W{1'b0}};
            done_q  <= {CNT_W{1'b0}};
            wdog_q  <= {WDOG_W{1'b0}};
            ev_q    <= 1'b0;
            er_q    <= 1'b1;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            rec_q   <= rec_d;
            done_q  <= done_d;
            wdog_q  <= wdog_d;
            ev_q    <= ev_d;
            er_q    <= er_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    assign rd_en        = (state_q == ST_FETCH);
    assign cmd_rec      = rec_q;
    assign op_type      = op_s;
    assign engine_valid = ev_q;
    assign engine_reset = er_q;
    assign done_cnt     = done_q;
    assign curr_state   = state_q;
    assign irq          = irq_q;
    assign err          = err_q;
    assign err_code     = code_q;

endmodule

// File: tb/tb_cmd_dispatcher.sv
// Self-checking bench for cmd_dispatcher: scenario table, hand-written corner sequences and
// randomized programs checked against a record-level reference model.
`timescale 1ns/1ps
module tb_cmd_dispatcher;

    localparam int WORD_W    = 32;
    localparam int CMD_WORDS = 8;
    localparam int CNT_W     = 7;
    localparam int WDOG_W    = 16;
    localparam int REC_W     = WORD_W * CMD_WORDS;
    localparam int LIMIT     = 20;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_FETCH = 3'd1;
    localparam logic [2:0] S_ISSUE = 3'd2;
    localparam logic [2:0] S_RUN   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
    localparam logic [2:0] S_ERROR = 3'd5;

    logic              clk = 1'b0;
    logic              rst, op_en, abort, irq_ack, valid, rd_en;
    logic              engine_valid, engine_ready, engine_reset, irq, err;
    logic [WORD_W-1:0] cmd;
    logic [CNT_W-1:0]  cmd_size, done_cnt;
    logic [REC_W-1:0]  cmd_rec;
    logic [2:0]        op_type, curr_state;
    logic [1:0]        err_code;

    cmd_dispatcher #(
        .WORD_W(WORD_W), .CMD_WORDS(CMD_WORDS), .CNT_W(CNT_W),
        .WDOG_W(WDOG_W), .WDOG_LIMIT(16'd20)
    ) dut (
        .clk(clk), .rst(rst), .op_en(op_en), .abort(abort), .irq_ack(irq_ack),
        .valid(valid), .rd_en(rd_en), .cmd(cmd), .cmd_size(cmd_size),
        .cmd_rec(cmd_rec), .op_type(op_type), .engine_valid(engine_valid),
        .engine_ready(engine_ready), .engine_reset(engine_reset), .done_cnt(done_cnt),
        .curr_state(curr_state), .irq(irq), .err(err), .err_code(err_code)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         size;
        logic [2:0] op0, op1, op2;
        int         d;
        logic [2:0] e_st;
        logic [1:0] e_code;
        int         e_done, e_pops, e_launch, e_ev;
    } vec_t;

    vec_t              tbl[8];
    int                n_chk = 0;
    int                n_fail = 0;
    logic [WORD_W-1:0] fifo[$];
    logic [REC_W-1:0]  exp_rec[4];
    logic [2:0]        ops_a[4];
    int                dly[4];
    int                pops, launches, ev_cycles, ev_cnt, cur_dly, gap_pct;
    logic              prev_ev;
    bit                hold_valid_low;

    task automatic chk(input string name, input logic [REC_W-1:0] act, input logic [REC_W-1:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: cycle budget expired", name);
    endtask

    // One clock: FWFT FIFO and engine responder driven here, observations taken #1 after the edge
    task automatic cyc();
        logic          pop, ev_now;
        logic [WORD_W-1:0] dummy;
        int            r;
        valid = (fifo.size() > 0) && !hold_valid_low && (int'($urandom_range(99)) >= gap_pct);
        cmd   = (fifo.size() > 0) ? fifo[0] : 32'hDEAD_BEEF;
        ev_now = engine_valid;
        if (ev_now && !prev_ev) begin
            launches++;
            ev_cnt = 0;
            r = pops / CMD_WORDS - 1;
            if (r >= 0 && r < 4) begin
                cur_dly = dly[r];
                chk("launch_rec", cmd_rec, exp_rec[r]);
                chk("launch_op", op_type, exp_rec[r][2:0]);
            end else begin
                cur_dly = 0;
            end
        end
        engine_ready = ev_now && (ev_cnt == cur_dly);
        pop = rd_en && valid;
        prev_ev = ev_now;
        @(posedge clk);
        #1;
        if (pop) begin
            dummy = fifo.pop_front();
            pops++;
        end
        if (ev_now) begin
            ev_cnt++;
            ev_cycles++;
        end
    endtask

    task automatic check_reset(input string tag);
        chk({tag, ".state"}, curr_state, S_IDLE);
        chk({tag, ".cmd_rec"}, cmd_rec, '0);
        chk({tag, ".engine_valid"}, engine_valid, 1'b0);
        chk({tag, ".engine_reset"}, engine_reset, 1'b1);
        chk({tag, ".done_cnt"}, done_cnt, 7'd0);
        chk({tag, ".irq"}, irq, 1'b0);
        chk({tag, ".err"}, err, 1'b0);
        chk({tag, ".err_code"}, err_code, 2'b00);
        chk({tag, ".rd_en"}, rd_en, 1'b0);
    endtask

    // Loads `size` records (op from ops_a) into the FIFO and pulses op_en for one cycle
    task automatic start(input int size);
        logic [WORD_W-1:0] w;
        fifo.delete();
        pops = 0; launches = 0; ev_cycles = 0; ev_cnt = 0; prev_ev = 1'b0;
        for (int r = 0; r < size; r++) begin
            for (int k = 0; k < CMD_WORDS; k++) begin
                w = $urandom();
                if (k == 0) w[2:0] = ops_a[r];
                exp_rec[r][k*WORD_W +: WORD_W] = w;
                fifo.push_back(w);
            end
        end
        cmd_size = CNT_W'(size);
        op_en = 1'b1;
        cyc();
        op_en = 1'b0;
    endtask

    task automatic finish_prog(input string tag, input logic [2:0] e_st, input logic [1:0] e_code,
                               input int e_done, input int e_pops, input int e_launch, input int e_ev);
        int n = 0;
        while (curr_state != S_DONE && curr_state != S_ERROR && n < 600) begin
            if (curr_state == S_ISSUE) chk({tag, ".issue_align"}, pops % CMD_WORDS, 0);
            cyc();
            n++;
        end
        if (n >= 600) fail_now({tag, ".wait_end"});
        chk({tag, ".state"}, curr_state, e_st);
        chk({tag, ".err_code"}, err_code, e_code);
        chk({tag, ".done_cnt"}, done_cnt, CNT_W'(e_done));
        chk({tag, ".pops"}, pops, e_pops);
        chk({tag, ".launches"}, launches, e_launch);
        chk({tag, ".ev_cycles"}, ev_cycles, e_ev);
        chk({tag, ".irq"}, irq, 1'b1);
        chk({tag, ".err"}, err, (e_st == S_ERROR));
        chk({tag, ".engine_valid"}, engine_valid, 1'b0);
        chk({tag, ".engine_reset"}, engine_reset, 1'b1);
        cyc();
        cyc();
        chk({tag, ".no_pop_after"}, pops, e_pops);
        chk({tag, ".irq_held"}, irq, 1'b1);
        irq_ack = 1'b1;
        cyc();
        irq_ack = 1'b0;
        chk({tag, ".ack_state"}, curr_state, S_IDLE);
        chk({tag, ".ack_irq"}, irq, 1'b0);
        chk({tag, ".ack_err"}, {err, err_code}, 3'b000);
        chk({tag, ".ack_done_kept"}, done_cnt, CNT_W'(e_done));
        fifo.delete();
    endtask

    // Record-level reference: walk the program applying the op rules in order
    task automatic predict(input int size, output logic [2:0] st, output logic [1:0] code,
                           output int done, output int p, output int l, output int ev);
        st = S_DONE; code = 2'b00; done = 0; p = 0; l = 0; ev = 0;
        for (int i = 0; i < size; i++) begin
            p += CMD_WORDS;
            if (ops_a[i] == 3'b000) begin
                done++;
            end else if (ops_a[i] == 3'b001 || ops_a[i] == 3'b100 || ops_a[i] == 3'b101) begin
                l++;
                if (dly[i] >= LIMIT) begin
                    ev += LIMIT; st = S_ERROR; code = 2'b10;
                    break;
                end
                ev += dly[i] + 1;
                done++;
            end else begin
                st = S_ERROR; code = 2'b01;
                break;
            end
        end
    endtask

    initial begin
        int         n, size, x, sel;
        logic [2:0] m_st;
        logic [1:0] m_code;
        int         m_done, m_pops, m_l, m_ev;

        rst = 1'b1; op_en = 1'b0; abort = 1'b0; irq_ack = 1'b0; valid = 1'b0;
        cmd = '0; cmd_size = '0; engine_ready = 1'b0; gap_pct = 0; hold_valid_low = 1'b0;
        prev_ev = 1'b0; pops = 0; launches = 0; ev_cycles = 0; ev_cnt = 0; cur_dly = 0;

        //           size op0     op1     op2     dly state    code   done pops launch ev
        tbl[0] = '{2, 3'b001, 3'b100, 3'b000, 5,  S_DONE,  2'b00, 2, 16, 2, 12};
        tbl[1] = '{3, 3'b000, 3'b010, 3'b001, 5,  S_ERROR, 2'b01, 1, 16, 0, 0};
        tbl[2] = '{1, 3'b001, 3'b000, 3'b000, 30, S_ERROR, 2'b10, 0, 8,  1, 20};
        tbl[3] = '{1, 3'b101, 3'b000, 3'b000, 19, S_DONE,  2'b00, 1, 8,  1, 20};
        tbl[4] = '{3, 3'b000, 3'b000, 3'b000, 0,  S_DONE,  2'b00, 3, 24, 0, 0};
        tbl[5] = '{2, 3'b101, 3'b111, 3'b000, 0,  S_ERROR, 2'b01, 1, 16, 1, 1};
        tbl[6] = '{0, 3'b000, 3'b000, 3'b000, 0,  S_DONE,  2'b00, 0, 0,  0, 0};
        tbl[7] = '{2, 3'b100, 3'b001, 3'b000, 20, S_ERROR, 2'b10, 0, 8,  1, 20};

        #12;
        check_reset("por");
        rst = 1'b0;
        for (int c = 0; c < 3; c++) cyc();
        chk("idle_hold.state", curr_state, S_IDLE);
        chk("idle_hold.rd_en", rd_en, 1'b0);

        for (int i = 0; i < 8; i++) begin
            ops_a[0] = tbl[i].op0; ops_a[1] = tbl[i].op1; ops_a[2] = tbl[i].op2; ops_a[3] = 3'b000;
            for (int r = 0; r < 4; r++) dly[r] = tbl[i].d;
            start(tbl[i].size);
            finish_prog($sformatf("vec%0d", i), tbl[i].e_st, tbl[i].e_code,
                        tbl[i].e_done, tbl[i].e_pops, tbl[i].e_launch, tbl[i].e_ev);
        end

        // Starved FIFO mid-record
        ops_a[0] = 3'b001; dly[0] = 2;
        start(1);
        n = 0;
        while (pops < 4 && n < 50) begin cyc(); n++; end
        if (n >= 50) fail_now("starve.wait_pops");
        hold_valid_low = 1'b1;
        for (int c = 0; c < 10; c++) begin
            chk("starve.rd_en", rd_en, 1'b1);
            chk("starve.state", curr_state, S_FETCH);
            cyc();
        end
        chk("starve.pops", pops, 4);
        hold_valid_low = 1'b0;
        finish_prog("starve", S_DONE, 2'b00, 1, 8, 1, 3);

        // Abort in RUN of the second record
        ops_a[0] = 3'b001; ops_a[1] = 3'b100; dly[0] = 1; dly[1] = 100;
        start(2);
        n = 0;
        while (!(launches == 2 && ev_cnt == 3) && n < 200) begin cyc(); n++; end
        if (n >= 200) fail_now("abrun.wait_run");
        chk("abrun.pre_state", curr_state, S_RUN);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abrun.state", curr_state, S_IDLE);
        chk("abrun.rd_en", rd_en, 1'b0);
        chk("abrun.engine_valid", engine_valid, 1'b0);
        chk("abrun.engine_reset", engine_reset, 1'b1);
        chk("abrun.irq", irq, 1'b0);
        chk("abrun.done_cnt", done_cnt, 7'd1);
        cyc();
        chk("abrun.stay_idle", curr_state, S_IDLE);
        fifo.delete();

        // Abort in FETCH at word 3
        ops_a[0] = 3'b001; dly[0] = 1;
        start(1);
        n = 0;
        while (pops < 3 && n < 50) begin cyc(); n++; end
        if (n >= 50) fail_now("abfetch.wait_pops");
        chk("abfetch.pre_state", curr_state, S_FETCH);
        abort = 1'b1;
        cyc();
        abort = 1'b0;
        chk("abfetch.state", curr_state, S_IDLE);
        chk("abfetch.rd_en", rd_en, 1'b0);
        chk("abfetch.engine_valid", engine_valid, 1'b0);
        chk("abfetch.irq", irq, 1'b0);
        chk("abfetch.done_cnt", done_cnt, 7'd0);
        n = pops;
        for (int c = 0; c < 3; c++) cyc();
        chk("abfetch.no_more_pops", pops, n);
        fifo.delete();

        // Randomized programs against the reference model
        for (int p = 0; p < 25; p++) begin
            size = $urandom_range(4, 1);
            for (int r = 0; r < 4; r++) begin
                x = $urandom_range(99);
                if (x < 25) begin
                    ops_a[r] = 3'b000;
                end else if (x < 85) begin
                    sel = $urandom_range(2);
                    ops_a[r] = (sel == 0) ? 3'b001 : ((sel == 1) ? 3'b100 : 3'b101);
                end else begin
                    ops_a[r] = 3'($urandom_range(7)) | 3'b010;
                end
                dly[r] = ($urandom_range(99) < 8) ? int'($urandom_range(25, 19)) : int'($urandom_range(6, 0));
            end
            predict(size, m_st, m_code, m_done, m_pops, m_l, m_ev);
            gap_pct = $urandom_range(40);
            start(size);
            finish_prog($sformatf("rand%0d", p), m_st, m_code, m_done, m_pops, m_l, m_ev);
        end
        gap_pct = 0;

        // Asynchronous reset while the engine is running
        ops_a[0] = 3'b001; dly[0] = 50;
        start(1);
        n = 0;
        while (curr_state != S_RUN && n < 50) begin cyc(); n++; end
        if (n >= 50) fail_now("rstrun.wait_run");
        cyc();
        chk("rstrun.pre_ev", engine_valid, 1'b1);
        #2 rst = 1'b1;
        #1;
        check_reset("rstrun");
        engine_ready = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("rstrun.after_state", curr_state, S_IDLE);
        fifo.delete();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
